// File: rtl/whack_game_ctrl.sv
// rtl/whack_game_ctrl.sv - whack-a-mole game sequencer: state, countdowns, score and high score
module whack_game_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int START_CYCLES = 300_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_restart,
  input  logic       add_1,
  input  logic       add_2,
  input  logic       reduce_2,
  output logic [1:0] game_state,
  output logic       seed_load,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [6:0] time_left,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] START_MAX = SW'(START_CYCLES - 1);
  localparam logic [6:0]    SECS      = 7'(GAME_SECONDS);

  typedef enum logic [1:0] {
    ST_RESTART = 2'b00,
    ST_START   = 2'b01,
    ST_PLAY    = 2'b10,
    ST_DIE     = 2'b11
  } state_t;

  state_t          state;
  logic [PW-1:0]   prescale;
  logic [SW-1:0]   start_cnt;
  logic            btn_start_q;
  logic            btn_restart_q;
  logic            start_rise;
  logic            restart_rise;
  logic signed [9:0] sum;
  logic [7:0]      next_score;

  assign game_state   = state;
  assign start_rise   = btn_start & ~btn_start_q;
  assign restart_rise = btn_restart & ~btn_restart_q;

  // All pulses are summed before the single clamp to 0..255
  always_comb begin
    sum = $signed({2'b00, score}) + $signed({9'b0, add_1}) + $signed({8'b0, add_2, 1'b0})
          - $signed({8'b0, reduce_2, 1'b0});
    next_score = sum[7:0];
    if (sum < 0)
      next_score = 8'd0;
    else if (sum > 10'sd255)
      next_score = 8'd255;
  end

  always_ff @(posedge clk) begin
    seed_load <= 1'b0;
    sec_tick  <= 1'b0;
    if (rst) begin
      state         <= ST_RESTART;
      score         <= 8'd0;
      high_score    <= 8'd0;
      time_left     <= SECS;
      prescale      <= '0;
      start_cnt     <= '0;
      btn_start_q   <= 1'b1;
      btn_restart_q <= 1'b1;
    end else begin
      btn_start_q   <= btn_start;
      btn_restart_q <= btn_restart;
      if (restart_rise) begin
        state     <= ST_RESTART;
        score     <= 8'd0;
        time_left <= SECS;
        prescale  <= '0;
        start_cnt <= '0;
      end else begin
        case (state)
          ST_RESTART: begin
            score     <= 8'd0;
            time_left <= SECS;
            prescale  <= '0;
            start_cnt <= '0;
            if (start_rise) begin
              state     <= ST_START;
              seed_load <= 1'b1;
            end
          end
          ST_START: begin
            if (start_cnt == START_MAX) begin
              state     <= ST_PLAY;
              prescale  <= '0;
              start_cnt <= '0;
            end else begin
              start_cnt <= start_cnt + 1'b1;
            end
          end
          ST_PLAY: begin
            score <= next_score;
            if (prescale == PRE_MAX) begin
              prescale  <= '0;
              sec_tick  <= 1'b1;
              time_left <= time_left - 7'd1;
              // Last second: the score counted on this edge competes for the high score
              if (time_left == 7'd1) begin
                state <= ST_DIE;
                if (next_score > high_score)
                  high_score <= next_score;
              end
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb/tb_whack_game_ctrl.sv - randomized bench for whack_game_ctrl against a cycle-count model
module tb_whack_game_ctrl;

  localparam int HZ = 10;
  localparam int GS = 3;
  localparam int SC = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_restart = 1'b0;
  logic       add_1 = 1'b0;
  logic       add_2 = 1'b0;
  logic       reduce_2 = 1'b0;
  logic [1:0] game_state;
  logic       seed_load;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [6:0] time_left;
  logic       sec_tick;

  whack_game_ctrl #(.CLK_HZ(HZ), .GAME_SECONDS(GS), .START_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_restart(btn_restart),
    .add_1(add_1), .add_2(add_2), .reduce_2(reduce_2),
    .game_state(game_state), .seed_load(seed_load), .score(score),
    .high_score(high_score), .time_left(time_left), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: the phase, and how many cycles have been spent in START and PLAY
  int m_phase = 0;
  int m_start_cycles = 0;
  int m_play_cycles = 0;
  int m_score = 0;
  int m_high = 0;
  int m_seed = 0;
  int m_tick = 0;
  int m_prev_s = 1;
  int m_prev_r = 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp)
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_edge();
    int rise_s, rise_r, s;
    rise_s = (btn_start && m_prev_s == 0) ? 1 : 0;
    rise_r = (btn_restart && m_prev_r == 0) ? 1 : 0;
    m_prev_s = btn_start;
    m_prev_r = btn_restart;
    m_seed = 0;
    m_tick = 0;
    if (rst) begin
      m_phase = 0; m_score = 0; m_high = 0; m_play_cycles = 0; m_start_cycles = 0;
      m_prev_s = 1; m_prev_r = 1;
    end else if (rise_r) begin
      m_phase = 0; m_score = 0; m_play_cycles = 0; m_start_cycles = 0;
    end else begin
      case (m_phase)
        0: if (rise_s) begin m_phase = 1; m_seed = 1; m_start_cycles = 0; end
        1: begin
          m_start_cycles++;
          if (m_start_cycles == SC) begin m_phase = 2; m_play_cycles = 0; end
        end
        2: begin
          s = m_score + add_1 + 2 * add_2 - 2 * reduce_2;
          m_score = (s < 0) ? 0 : (s > 255) ? 255 : s;
          m_play_cycles++;
          if (m_play_cycles % HZ == 0) m_tick = 1;
          if (m_play_cycles == GS * HZ) begin
            m_phase = 3;
            if (m_score > m_high) m_high = m_score;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("game_state", game_state, m_phase);
    check("seed_load", seed_load, m_seed);
    check("score", score, m_score);
    check("high_score", high_score, m_high);
    check("time_left", time_left, GS - m_play_cycles / HZ);
    check("sec_tick", sec_tick, m_tick);
  endtask

  task automatic rand_pulses(input int rate);
    add_1    = ($urandom_range(0, 99) < rate);
    add_2    = ($urandom_range(0, 99) < rate);
    reduce_2 = ($urandom_range(0, 99) < rate);
  endtask

  initial begin
    // Reset with btn_start held, then keep holding: no edge, no seed
    btn_start = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    btn_start = 1'b0; step();
    btn_start = 1'b1; repeat (2) step();
    btn_start = 1'b0;
    // Round with no hits, then dwell in DIE
    repeat (40) step();
    btn_restart = 1'b1; step();
    btn_restart = 1'b0; step();

    for (int r = 0; r < 40; r++) begin
      int rate, abort_at;
      rate     = $urandom_range(10, 60);
      abort_at = (r % 4 == 2) ? $urandom_range(2, 38) : -1;
      btn_start = 1'b1; step();
      btn_start = 1'b0;
      for (int c = 0; c < 45; c++) begin
        rand_pulses(rate);
        btn_start   = ($urandom_range(0, 9) == 0);
        btn_restart = (c == abort_at);
        rst         = (r % 10 == 7) && (c == 44);
        step();
      end
      {add_1, add_2, reduce_2, btn_start, btn_restart, rst} = '0;
      step();
      btn_restart = 1'b1; step();
      btn_restart = 1'b0; step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
# whack_game_ctrl

Top-level game sequencer for the whack-a-mole design. It owns the 2-bit `game_state` consumed by the mole generator, the VGA renderer and the seven-segment display. It issues the one-cycle LFSR seed-load pulse and runs the pre-game countdown and the in-game seconds timer. It accumulates the score from the mole generator's `add_1` / `add_2` / `reduce_2` pulses and keeps a high score across rounds.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, `clk` cycles per second tick.
- `GAME_SECONDS`, 60, round length in seconds (1..127).
- `START_CYCLES`, 300_000_000, cycles spent in START before PLAY (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `btn_start`  in  1  debounced, clk-synchronous level; rising edge starts a round.
- `btn_restart`  in  1  debounced, clk-synchronous level; rising edge aborts to RESTART.
- `add_1`  in  1  one-cycle pulse, score +1.
- `add_2`  in  1  one-cycle pulse, score +2.
- `reduce_2`  in  1  one-cycle pulse, score −2.
- `game_state`  out  2  RESTART=00, START=01, PLAY=10, DIE=11.
- `seed_load`  out  1  one-cycle pulse to the LFSR load input.
- `score`  out  8  current round score, unsigned.
- `high_score`  out  8  best completed-round score.
- `time_left`  out  7  seconds remaining.
- `sec_tick`  out  1  one-cycle pulse per elapsed PLAY second.

## Operation
- Reset values:
  - `game_state`=RESTART, `seed_load`=0, `score`=0, `high_score`=0, `time_left`=GAME_SECONDS, `sec_tick`=0.
  - Prescaler and start counter = 0.
  - Button history registers = 1, so a button held through reset produces no edge.
- Edge detect: `rise = btn & ~btn_q`, with `btn_q` registered each cycle.
- Priority: `rst` > `btn_restart` rise > state-specific transitions.
- A `btn_restart` rise in any state moves to RESTART on the next edge.
- RESTART:
  - `score`=0, `time_left`=GAME_SECONDS, counters cleared.
  - A `btn_start` rise moves to START; `seed_load`=1 on the same edge, for exactly one cycle.
- START:
  - Start counter increments from 0.
  - When it equals START_CYCLES−1, move to PLAY and clear the prescaler.
  - `btn_start` is ignored.
- PLAY:
  - The prescaler counts 0..CLK_HZ−1 and wraps.
  - At wrap: `sec_tick`=1 for one cycle and `time_left` decrements.
  - If `time_left` was 1 at the wrap, `time_left` becomes 0 and the state becomes DIE on the same edge.
- Score arithmetic in PLAY only:
  - delta = add_1 + 2·add_2 − 2·reduce_2, computed in signed 10 bits.
  - New score = clamp(score + delta, 0, 255).
  - Simultaneous pulses are summed before clamping. Example: score 1 with add_1 and reduce_2 together gives 0. Score 0 with add_2 and reduce_2 together gives 0.
  - Pulses on the PLAY→DIE edge cycle are counted.
  - Pulses in any other state are ignored.
- DIE:
  - `score` and `time_left` (0) are held.
  - On the entry edge, `high_score` = max(`high_score`, final score). The comparison includes any pulse counted on that same edge.
  - `btn_start` is ignored; only a `btn_restart` rise leaves DIE.
- An aborted round (`btn_restart` during START or PLAY) does not update `high_score`.
- `high_score` is cleared only by `rst`.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Score pulse at cycle n: `score` reflects it at n+1.
- `btn_start` rising at cycle n (in RESTART): `game_state`=START and `seed_load`=1 at n+1; `seed_load`=0 at n+2.
- START lasts exactly START_CYCLES cycles of `game_state`=01.
- First PLAY second: `sec_tick` on the CLK_HZ-th PLAY cycle.
- A full round runs GAME_SECONDS·CLK_HZ PLAY cycles.
- `rst` mid-round returns every output to its reset value on the next edge, `high_score` included.

## Test plan
Bench settings: CLK_HZ=10, GAME_SECONDS=3, START_CYCLES=5.
- Reset with `btn_start` held high → stays RESTART, `seed_load` never asserts. Release then press → START one cycle later, `seed_load` a single-cycle pulse.
- Full round, no hits → 5 cycles START, then `sec_tick` every 10 cycles. `time_left` goes 3,2,1,0, DIE after exactly 30 PLAY cycles, `high_score`=0.
- In PLAY: add_2, add_2, add_1, then reduce_2 ×3 → `score` 2,4,5,3,1,0. Underflow clamps at 0.
- Simultaneous pulses: score 4, add_1+add_2+reduce_2 in one cycle → 5. Pulses during START and DIE → `score` unchanged.
- Round ends with score 7 (add_1 on the final tick cycle included); second round ends with 4 → `high_score` 7 after the first round and stays 7 after the second.
- `btn_restart` mid-PLAY at score 9 → RESTART next cycle, `score`=0, `time_left`=3, `high_score` unchanged. `rst` in DIE → all outputs at reset values.
